tc_dbuffer_pp: RTL and testbench
================================

# tc_dbuffer_pp

Parametrised ping-pong accumulator buffer for the sparse tensor core's D/C matrix. Two M×N banks: the compute bank serves tile reads and tile writes (overwrite or saturating accumulate) from the PE array. The I/O bank is row-loaded from memory and row-drained back through a valid/ready stream. A swap handshake exchanges the banks, so loading and draining of one output block overlap with computation on the next.

## Interface
- M, 16, matrix rows per bank
- N, 16, matrix columns per bank
- TILE_M, 4, tile rows; M % TILE_M == 0
- TILE_N, 4, tile columns; N % TILE_N == 0
- DW_DATA, 16, signed element width
- DW_MEM, N*DW_DATA, memory row width
- CLR_ON_DRAIN, 1, when 1 each drained row is zeroed after its handshake
- Derived (localparam): TILE_SIZE=TILE_M*TILE_N, NUM_TILE=(M/TILE_M)*(N/TILE_N), DW_PTR=clog2(NUM_TILE), DW_ROW=clog2(M)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ld_valid  in  1  row-load request
- ld_ready  out  1  row load accepted this cycle
- ld_row  in  DW_ROW  destination row in I/O bank
- ld_data  in  DW_MEM  row data; element j at [j*DW_DATA +: DW_DATA]
- dr_req  in  1  start draining the I/O bank (pulse or level)
- dr_valid  out  1  dr_data holds a valid row
- dr_ready  in  1  consumer accepts row
- dr_row  out  DW_ROW  index of row on dr_data
- dr_data  out  DW_MEM  drained row
- dr_last  out  1  dr_row == M-1 while dr_valid
- tile_rd_ptr  in  DW_PTR  compute-bank tile to read
- C_tile  out  TILE_SIZE*DW_DATA  registered tile; element (r,c) at [(r*TILE_N+c)*DW_DATA +: DW_DATA]
- tile_wr_en  in  1  write tile to compute bank
- tile_wr_ptr  in  DW_PTR  tile to write
- tile_acc  in  1  0: overwrite, 1: accumulate
- D_tile  in  TILE_SIZE*DW_DATA  write data, same layout as C_tile
- swap_req  in  1  level request to exchange banks
- swap_ack  out  1  one-cycle pulse on the swap edge
- bank_sel  out  1  index of current compute bank

## Operation
- Tile p covers rows (p / (N/TILE_N))*TILE_M plus r, and columns (p % (N/TILE_N))*TILE_N plus c.
- Tile read: on every edge, C_tile <= compute-bank tile[tile_rd_ptr]. Read-before-write: a same-cycle write to the same tile is not visible until the next read.
- Tile write with tile_acc=0 stores D_tile.
- Tile write with tile_acc=1 stores sat(old + D_tile) per element, using signed DW_DATA saturation. Clamp to 2^(DW_DATA-1)-1 or -2^(DW_DATA-1); no wrap.
- Load: ld_ready = (state==IDLE) && !swap_req. When ld_valid && ld_ready, the I/O bank row ld_row is set to ld_data. Writes with ld_row ≥ M are dropped.
- Outside FSM has states IDLE, DRAIN, and its state output is registered.
  - IDLE to DRAIN on dr_req, when swap_req is low. The row counter is set to 0, and dr_data is loaded with I/O row 0.
  - In DRAIN, dr_valid=1. On dr_valid && dr_ready, the current row is zeroed if CLR_ON_DRAIN=1.
  - If the row was not the last, the counter increments and dr_data reloads with the next row.
  - If dr_last, the FSM returns to IDLE and dr_valid drops.
  - With dr_ready low, dr_data, dr_row and dr_valid hold stable.
- Swap: when swap_req=1 and state==IDLE, the swap happens on that edge. bank_sel toggles and swap_ack pulses for one cycle.
  - A tile write in the swap cycle lands in the old compute bank.
  - A tile read in the swap cycle returns old-bank data.
  - Requests from the next cycle onward target the new bank.
- dr_req and swap_req high together in IDLE: the swap wins, and dr_req is ignored that cycle.
- swap_req during DRAIN waits. The swap takes effect on the first IDLE edge.

## Timing
- Reset (reset=0, async) clears:
  - both banks to 0
  - bank_sel=0, state=IDLE
  - ld_ready, dr_valid, dr_last, swap_ack = 0; dr_row=0, dr_data=0, C_tile=0
  - ld_ready rises in the first cycle after release, provided swap_req is low.
- Tile read latency is 1 cycle. Tile write and accumulate complete in 1 cycle, and back-to-back accumulates to one tile each cycle are correct.
- Load takes effect in 1 cycle. A drain row read the cycle after a load to that row sees the new data.
- Drain: dr_valid is high 1 cycle after dr_req is sampled. With dr_ready held high, one row per cycle, M cycles total. IDLE is reached the cycle after the dr_last handshake.
- Swap: bank_sel changes and swap_ack is high in the cycle after the sampled request.
- Reset asserted mid-drain or mid-swap aborts immediately with full reset values; no partial row is emitted.

## Test plan
- Load rows 0..15 with element (i,j)=i*16+j, then swap → bank_sel=1, swap_ack pulses once. Read tile 5 next cycle → element (0,0)=0x0044, element (3,3)=0x0077.
- Overwrite tile 0 with all 0x0001, then accumulate tile 0 with all 0x0002 on consecutive cycles → tile 0 reads 0x0003 in every element; other tiles unchanged.
- Accumulate 0x7FF0 + 0x0020 → 0x7FFF. Accumulate 0x8005 + 0xFFF0 → 0x8000.
- Swap back, then drain with dr_ready toggling 1,0,1,0 → rows 0..15 in order, each held stable while dr_ready=0. dr_last only on row 15. With CLR_ON_DRAIN=1, a second drain returns all zeros.
- Assert swap_req and dr_req together in IDLE → swap occurs, no dr_valid. Assert swap_req mid-drain → swap only after the dr_last handshake. ld_ready is 0 while swap_req is high.
- Assert reset at drain row 7 → all outputs 0 and both banks read zero after release.

Source files
------------

// File: rtl/tc_dbuffer_pp.sv
// rtl/tc_dbuffer_pp.sv - ping-pong M x N accumulator buffer with tile compute port and row load/drain stream
module tc_dbuffer_pp #(
  parameter int  M            = 16,
  parameter int  N            = 16,
  parameter int  TILE_M       = 4,
  parameter int  TILE_N       = 4,
  parameter int  DW_DATA      = 16,
  parameter int  DW_MEM       = N*DW_DATA,
  parameter bit  CLR_ON_DRAIN = 1'b1,
  localparam int TILE_SIZE    = TILE_M*TILE_N,
  localparam int NUM_TILE     = (M/TILE_M)*(N/TILE_N),
  localparam int DW_PTR       = $clog2(NUM_TILE),
  localparam int DW_ROW       = $clog2(M)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [DW_ROW-1:0]            ld_row,
  input  logic [DW_MEM-1:0]            ld_data,
  input  logic                         dr_req,
  output logic                         dr_valid,
  input  logic                         dr_ready,
  output logic [DW_ROW-1:0]            dr_row,
  output logic [DW_MEM-1:0]            dr_data,
  output logic                         dr_last,
  input  logic [DW_PTR-1:0]            tile_rd_ptr,
  output logic [TILE_SIZE*DW_DATA-1:0] C_tile,
  input  logic                         tile_wr_en,
  input  logic [DW_PTR-1:0]            tile_wr_ptr,
  input  logic                         tile_acc,
  input  logic [TILE_SIZE*DW_DATA-1:0] D_tile,
  input  logic                         swap_req,
  output logic                         swap_ack,
  output logic                         bank_sel
);
  localparam int TILES_PER_ROW = N/TILE_N;
  localparam int DW_COL        = $clog2(N);

  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [DW_DATA-1:0]           bank [2][M][N];
  logic [DW_DATA-1:0]           wr_val [TILE_M][TILE_N];
  logic [TILE_SIZE*DW_DATA-1:0] rd_tile;
  logic [DW_MEM-1:0]            src_data;
  logic [DW_ROW-1:0]            rd_r0, wr_r0, src_row;
  logic [DW_COL-1:0]            rd_c0, wr_c0;
  logic                         io_sel, swap_go, drain_start, drain_hs, row_is_last;

  function automatic logic [DW_DATA-1:0] sat_add(input logic [DW_DATA-1:0] a, input logic [DW_DATA-1:0] b);
    logic [DW_DATA:0] s;
    s = {a[DW_DATA-1], a} + {b[DW_DATA-1], b};
    if (s[DW_DATA] != s[DW_DATA-1])
      return s[DW_DATA] ? {1'b1, {(DW_DATA-1){1'b0}}} : {1'b0, {(DW_DATA-1){1'b1}}};
    return s[DW_DATA-1:0];
  endfunction

  assign io_sel      = ~bank_sel;
  assign row_is_last = (dr_row == DW_ROW'(M-1));
  assign ld_ready    = reset && (state == IDLE) && !swap_req;
  assign dr_valid    = (state == DRAIN);
  assign dr_last     = dr_valid && row_is_last;

  assign rd_r0 = DW_ROW'((int'(tile_rd_ptr) / TILES_PER_ROW) * TILE_M);
  assign rd_c0 = DW_COL'((int'(tile_rd_ptr) % TILES_PER_ROW) * TILE_N);
  assign wr_r0 = DW_ROW'((int'(tile_wr_ptr) / TILES_PER_ROW) * TILE_M);
  assign wr_c0 = DW_COL'((int'(tile_wr_ptr) % TILES_PER_ROW) * TILE_N);

  // Tile read and accumulate both see the pre-edge bank contents (read-before-write).
  always_comb begin
    rd_tile = '0;
    for (int r = 0; r < TILE_M; r++) begin
      for (int c = 0; c < TILE_N; c++) begin
        rd_tile[(r*TILE_N+c)*DW_DATA +: DW_DATA] = bank[bank_sel][rd_r0 + DW_ROW'(r)][rd_c0 + DW_COL'(c)];
        wr_val[r][c] = tile_acc
          ? sat_add(bank[bank_sel][wr_r0 + DW_ROW'(r)][wr_c0 + DW_COL'(c)], D_tile[(r*TILE_N+c)*DW_DATA +: DW_DATA])
          : D_tile[(r*TILE_N+c)*DW_DATA +: DW_DATA];
      end
    end
  end

  assign src_row = drain_start ? '0 : dr_row + DW_ROW'(1);

  always_comb begin
    src_data = '0;
    for (int j = 0; j < N; j++)
      src_data[j*DW_DATA +: DW_DATA] = bank[io_sel][src_row][DW_COL'(j)];
  end

  always_comb begin
    state_nxt   = state;
    swap_go     = 1'b0;
    drain_start = 1'b0;
    drain_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (swap_req) begin
          swap_go = 1'b1;
        end else if (dr_req) begin
          drain_start = 1'b1;
          state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        if (dr_ready) begin
          drain_hs = 1'b1;
          if (row_is_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bank_sel <= 1'b0;
      swap_ack <= 1'b0;
      dr_row   <= '0;
      dr_data  <= '0;
      C_tile   <= '0;
    end else begin
      state    <= state_nxt;
      swap_ack <= swap_go;
      C_tile   <= rd_tile;
      if (swap_go) bank_sel <= ~bank_sel;
      if (drain_start || (drain_hs && !row_is_last)) begin
        dr_row  <= src_row;
        dr_data <= src_data;
      end
    end
  end

  // Compute-port writes hit bank_sel, load/clear hit the other bank, so they never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < M; r++)
          for (int c = 0; c < N; c++)
            bank[b][r][c] <= '0;
    end else begin
      if (tile_wr_en && (int'(tile_wr_ptr) < NUM_TILE)) begin
        for (int r = 0; r < TILE_M; r++)
          for (int c = 0; c < TILE_N; c++)
            bank[bank_sel][wr_r0 + DW_ROW'(r)][wr_c0 + DW_COL'(c)] <= wr_val[r][c];
      end
      if (ld_valid && ld_ready && (int'(ld_row) < M)) begin
        for (int j = 0; j < N; j++)
          bank[io_sel][ld_row][DW_COL'(j)] <= ld_data[j*DW_DATA +: DW_DATA];
      end
      if (drain_hs && CLR_ON_DRAIN) begin
        for (int j = 0; j < N; j++)
          bank[io_sel][dr_row][DW_COL'(j)] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tc_dbuffer_pp.sv
// tb/tb_tc_dbuffer_pp.sv - scoreboard bench for tc_dbuffer_pp
module tb_tc_dbuffer_pp;
  localparam int M = 16, N = 16, TM = 4, TN = 4, DW = 16;
  localparam int DWM = N*DW, TS = TM*TN;

  logic            clk = 1'b0, reset = 1'b0;
  logic            ld_valid = 1'b0, ld_ready;
  logic [3:0]      ld_row = '0;
  logic [DWM-1:0]  ld_data = '0;
  logic            dr_req = 1'b0, dr_valid, dr_ready = 1'b0, dr_last;
  logic [3:0]      dr_row;
  logic [DWM-1:0]  dr_data;
  logic [3:0]      tile_rd_ptr = '0, tile_wr_ptr = '0;
  logic [TS*DW-1:0] C_tile, D_tile = '0;
  logic            tile_wr_en = 1'b0, tile_acc = 1'b0;
  logic            swap_req = 1'b0, swap_ack, bank_sel;

  tc_dbuffer_pp dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_row(ld_row), .ld_data(ld_data),
    .dr_req(dr_req), .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_row(dr_row),
    .dr_data(dr_data), .dr_last(dr_last),
    .tile_rd_ptr(tile_rd_ptr), .C_tile(C_tile), .tile_wr_en(tile_wr_en),
    .tile_wr_ptr(tile_wr_ptr), .tile_acc(tile_acc), .D_tile(D_tile),
    .swap_req(swap_req), .swap_ack(swap_ack), .bank_sel(bank_sel)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] row; logic [DWM-1:0] data; } drow_t;

  int checks = 0, errors = 0;
  logic [15:0] mb [2][M][N];
  int msel = 0;
  bit mdrain = 1'b0;
  drow_t dq[$];
  logic [TS*DW-1:0] tq[$];

  function automatic logic [15:0] msat(logic [15:0] a, logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic logic [TS*DW-1:0] model_tile(int b, int p);
    logic [TS*DW-1:0] t;
    int r0, c0;
    r0 = (p / (N/TN)) * TM;
    c0 = (p % (N/TN)) * TN;
    for (int r = 0; r < TM; r++)
      for (int c = 0; c < TN; c++)
        t[(r*TN+c)*DW +: DW] = mb[b][r0+r][c0+c];
    return t;
  endfunction

  function automatic logic [DWM-1:0] model_row(int b, int r);
    logic [DWM-1:0] d;
    for (int j = 0; j < N; j++) d[j*DW +: DW] = mb[b][r][j];
    return d;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          mb[b][r][c] = '0;
    msel = 0;
    mdrain = 1'b0;
    dq.delete();
    tq.delete();
  endtask

  // One clock: check pre-edge outputs, advance the model, clock, check post-edge outputs.
  task automatic step();
    bit idle, hold, exp_ack;
    logic [DWM-1:0] hold_data;
    logic [3:0] hold_row;
    logic [TS*DW-1:0] et;
    drow_t it;
    int r0, c0;
    #1;
    idle = !mdrain;
    checks++;
    if (ld_ready !== (idle && !swap_req)) begin
      errors++; $display("FAIL ld_ready: got %b want %b", ld_ready, idle && !swap_req);
    end
    checks++;
    if (dr_valid !== mdrain) begin
      errors++; $display("FAIL dr_valid: got %b want %b", dr_valid, mdrain);
    end
    if (mdrain) begin
      if (dq.size() == 0) begin
        checks++; errors++; $display("FAIL drain_queue: got empty want row");
      end else begin
        it = dq[0];
        checks++;
        if (dr_row !== it.row || dr_data !== it.data) begin
          errors++; $display("FAIL drain_row: got row %0d data %h want row %0d data %h", dr_row, dr_data, it.row, it.data);
        end
        checks++;
        if (dr_last !== (it.row == 4'd15)) begin
          errors++; $display("FAIL dr_last: got %b want %b (row %0d)", dr_last, it.row == 4'd15, it.row);
        end
        if (dr_ready) begin
          void'(dq.pop_front());
          for (int j = 0; j < N; j++) mb[msel^1][it.row][j] = '0;
          if (it.row == 4'd15) mdrain = 1'b0;
        end
      end
    end else begin
      checks++;
      if (dr_last !== 1'b0) begin
        errors++; $display("FAIL dr_last_idle: got %b want 0", dr_last);
      end
    end
    hold = !idle && !dr_ready;
    hold_data = dr_data;
    hold_row = dr_row;
    tq.push_back(model_tile(msel, int'(tile_rd_ptr)));
    if (tile_wr_en) begin
      r0 = (int'(tile_wr_ptr) / (N/TN)) * TM;
      c0 = (int'(tile_wr_ptr) % (N/TN)) * TN;
      for (int r = 0; r < TM; r++)
        for (int c = 0; c < TN; c++)
          mb[msel][r0+r][c0+c] = tile_acc ? msat(mb[msel][r0+r][c0+c], D_tile[(r*TN+c)*DW +: DW])
                                          : D_tile[(r*TN+c)*DW +: DW];
    end
    if (ld_valid && idle && !swap_req)
      for (int j = 0; j < N; j++) mb[msel^1][ld_row][j] = ld_data[j*DW +: DW];
    exp_ack = 1'b0;
    if (idle && swap_req) begin
      msel ^= 1;
      exp_ack = 1'b1;
    end else if (idle && dr_req) begin
      mdrain = 1'b1;
      for (int r = 0; r < M; r++) begin
        it.row = r[3:0];
        it.data = model_row(msel^1, r);
        dq.push_back(it);
      end
    end
    @(posedge clk);
    #1;
    et = tq.pop_front();
    checks++;
    if (C_tile !== et) begin
      errors++; $display("FAIL C_tile: got %h want %h", C_tile, et);
    end
    checks++;
    if (bank_sel !== msel[0] || swap_ack !== exp_ack) begin
      errors++; $display("FAIL swap: got sel %b ack %b want sel %b ack %b", bank_sel, swap_ack, msel[0], exp_ack);
    end
    if (hold) begin
      checks++;
      if (dr_valid !== 1'b1 || dr_row !== hold_row || dr_data !== hold_data) begin
        errors++; $display("FAIL drain_hold: got v %b row %0d want v 1 row %0d", dr_valid, dr_row, hold_row);
      end
    end
  endtask

  task automatic fill_d(logic [15:0] v);
    for (int i = 0; i < TS; i++) D_tile[i*DW +: DW] = v;
  endtask

  task automatic test_reset();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ld_ready !== 1'b0 || dr_valid !== 1'b0 || dr_last !== 1'b0 || swap_ack !== 1'b0 ||
        bank_sel !== 1'b0 || dr_row !== 4'd0 || dr_data !== '0 || C_tile !== '0) begin
      errors++; $display("FAIL reset_state: got rdy %b v %b sel %b ack %b want all 0", ld_ready, dr_valid, bank_sel, swap_ack);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++; $display("FAIL ld_ready_release: got %b want 1", ld_ready);
    end
  endtask

  task automatic test_load_swap();
    for (int i = 0; i < M; i++) begin
      ld_valid = 1'b1;
      ld_row = i[3:0];
      for (int j = 0; j < N; j++) ld_data[j*DW +: DW] = 16'(i*16 + j);
      step();
    end
    ld_valid = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    tile_rd_ptr = 4'd5;
    step();
    checks++;
    if (C_tile[0 +: DW] !== 16'h0044 || C_tile[15*DW +: DW] !== 16'h0077) begin
      errors++; $display("FAIL tile5: got %h %h want 0044 0077", C_tile[0 +: DW], C_tile[15*DW +: DW]);
    end
  endtask

  task automatic test_tile_write();
    tile_wr_en = 1'b1; tile_wr_ptr = 4'd0; tile_acc = 1'b0; fill_d(16'h0001);
    step();
    tile_acc = 1'b1; fill_d(16'h0002);
    step();
    tile_wr_en = 1'b0; tile_rd_ptr = 4'd0;
    step();
    for (int i = 0; i < TS; i++) begin
      checks++;
      if (C_tile[i*DW +: DW] !== 16'h0003) begin
        errors++; $display("FAIL tile0_acc[%0d]: got %h want 0003", i, C_tile[i*DW +: DW]);
      end
    end
    tile_rd_ptr = 4'd1;
    step();
    tile_rd_ptr = 4'd3; tile_wr_en = 1'b1; tile_wr_ptr = 4'd3; tile_acc = 1'b0; fill_d(16'h0055);
    step();
    tile_wr_en = 1'b0;
    step();
  endtask

  task automatic test_saturate();
    tile_wr_en = 1'b1; tile_wr_ptr = 4'd2; tile_acc = 1'b0; fill_d(16'h1234);
    D_tile[0 +: DW] = 16'h7FF0; D_tile[DW +: DW] = 16'h8005;
    step();
    tile_acc = 1'b1; fill_d(16'h0000);
    D_tile[0 +: DW] = 16'h0020; D_tile[DW +: DW] = 16'hFFF0;
    step();
    tile_wr_en = 1'b0; tile_acc = 1'b0; tile_rd_ptr = 4'd2;
    step();
    checks++;
    if (C_tile[0 +: DW] !== 16'h7FFF || C_tile[DW +: DW] !== 16'h8000) begin
      errors++; $display("FAIL saturate: got %h %h want 7fff 8000", C_tile[0 +: DW], C_tile[DW +: DW]);
    end
  endtask

  task automatic run_drain(bit toggle);
    int n;
    n = 0;
    dr_req = 1'b1;
    step();
    dr_req = 1'b0;
    for (int k = 0; k < 64 && mdrain; k++) begin
      dr_ready = toggle ? (k % 2 == 0) : 1'b1;
      if (dr_ready) n++;
      step();
    end
    dr_ready = 1'b0;
    checks++;
    if (mdrain || n != 16) begin
      errors++; $display("FAIL drain_count: got %0d handshakes want 16", n);
    end
    step();
  endtask

  task automatic test_drain();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    run_drain(1'b1);
    run_drain(1'b0);
  endtask

  task automatic test_swap_priority();
    int sel0, cnt;
    sel0 = msel;
    swap_req = 1'b1; dr_req = 1'b1;
    step();
    swap_req = 1'b0; dr_req = 1'b0;
    step();
    checks++;
    if (bank_sel !== ~sel0[0] || dr_valid !== 1'b0) begin
      errors++; $display("FAIL swap_priority: got sel %b v %b want sel %b v 0", bank_sel, dr_valid, ~sel0[0]);
    end
    dr_req = 1'b1; dr_ready = 1'b1;
    step();
    dr_req = 1'b0; swap_req = 1'b1;
    sel0 = msel;
    cnt = 0;
    for (int k = 0; k < 40 && msel == sel0; k++) begin
      step();
      cnt++;
    end
    swap_req = 1'b0; dr_ready = 1'b0;
    checks++;
    if (cnt != 17) begin
      errors++; $display("FAIL swap_in_drain: got swap after %0d cycles want 17", cnt);
    end
    step();
  endtask

  task automatic test_reset_mid_drain();
    ld_valid = 1'b1; ld_row = 4'd12;
    for (int j = 0; j < N; j++) ld_data[j*DW +: DW] = 16'(16'hA000 + j);
    step();
    ld_valid = 1'b0; dr_req = 1'b1; dr_ready = 1'b1;
    step();
    dr_req = 1'b0;
    for (int k = 0; k < 40 && dq.size() > 0 && dq[0].row != 4'd7; k++) step();
    checks++;
    if (dq.size() == 0 || dq[0].row != 4'd7) begin
      errors++; $display("FAIL reach_row7: got no row 7 want row 7");
    end
    reset = 1'b0;
    #1;
    checks++;
    if (dr_valid !== 1'b0 || dr_last !== 1'b0 || dr_row !== 4'd0 || dr_data !== '0 || C_tile !== '0 ||
        bank_sel !== 1'b0 || swap_ack !== 1'b0 || ld_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got v %b row %0d sel %b rdy %b want all 0", dr_valid, dr_row, bank_sel, ld_ready);
    end
    dr_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int p = 0; p < 16; p++) begin
      tile_rd_ptr = p[3:0];
      step();
    end
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    for (int p = 0; p < 17; p++) begin
      tile_rd_ptr = 4'(p);
      step();
    end
  endtask

  initial begin
    test_reset();
    test_load_swap();
    test_tile_write();
    test_saturate();
    test_drain();
    test_swap_priority();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
